// File: rtl/id_ex_operand_stage.sv
// ID->EX operand stage: forwards EX/MEM/WB results into the ID operands, holds ID
// for one bubble on a load-use hazard, and registers operands/control for EX.
module id_ex_operand_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_use_imm,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  rf_data1,
    input  logic [XLEN-1:0]  rf_data2,
    input  logic [XLEN-1:0]  ex_alu_result,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic [XLEN-1:0]  mem_data,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_write,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             flush,
    output logic             stall_id,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_op_a,
    output logic [XLEN-1:0]  ex_op_b,
    output logic [XLEN-1:0]  ex_store_data,
    output logic [4:0]       ex_rd,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic [XLEN-1:0]  ex_pc,
    output logic [CNT_W-1:0] bubble_count
);

    typedef enum logic {
        RUN,
        BUBBLE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t          state;
    state_t          state_next;
    logic            ex_fwd_ok;
    logic            hazard;
    logic            insert_bubble;
    logic            count_inc;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    // A load in EX has no result yet, so only non-load EX instructions may forward.
    assign ex_fwd_ok = ex_valid & ex_reg_write & ~ex_mem_read;

    always_comb begin
        fwd_rs1 = rf_data1;
        if (id_rs1 == 5'd0) begin
            fwd_rs1 = '0;
        end else if (ex_fwd_ok && (ex_rd == id_rs1)) begin
            fwd_rs1 = ex_alu_result;
        end else if (mem_reg_write && (mem_rd == id_rs1)) begin
            fwd_rs1 = mem_data;
        end else if (wb_reg_write && (wb_rd == id_rs1)) begin
            fwd_rs1 = wb_data;
        end
    end

    always_comb begin
        fwd_rs2 = rf_data2;
        if (id_rs2 == 5'd0) begin
            fwd_rs2 = '0;
        end else if (ex_fwd_ok && (ex_rd == id_rs2)) begin
            fwd_rs2 = ex_alu_result;
        end else if (mem_reg_write && (mem_rd == id_rs2)) begin
            fwd_rs2 = mem_data;
        end else if (wb_reg_write && (wb_rd == id_rs2)) begin
            fwd_rs2 = wb_data;
        end
    end

    assign hazard = id_valid & ex_valid & ex_mem_read & (ex_rd != 5'd0) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                     (id_uses_rs2 & (id_rs2 == ex_rd)));

    assign stall_id = hazard & ~flush;

    always_comb begin
        state_next    = state;
        count_inc     = 1'b0;
        insert_bubble = flush | ~id_valid;
        case (state)
            RUN: begin
                if (!flush && hazard) begin
                    state_next    = BUBBLE;
                    count_inc     = 1'b1;
                    insert_bubble = 1'b1;
                end
            end
            BUBBLE: begin
                state_next = RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase
        if (flush) begin
            state_next = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_count <= '0;
        end else if (count_inc && (bubble_count != {CNT_W{1'b1}})) begin
            bubble_count <= bubble_count + CNT_ONE;
        end
    end

    // Bubbles clear the whole EX register so stale operands never leak downstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid      <= 1'b0;
            ex_op_a       <= '0;
            ex_op_b       <= '0;
            ex_store_data <= '0;
            ex_rd         <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_pc         <= '0;
        end else if (insert_bubble) begin
            ex_valid      <= 1'b0;
            ex_op_a       <= '0;
            ex_op_b       <= '0;
            ex_store_data <= '0;
            ex_rd         <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_pc         <= '0;
        end else begin
            ex_valid      <= 1'b1;
            ex_op_a       <= fwd_rs1;
            ex_op_b       <= id_use_imm ? id_imm : fwd_rs2;
            ex_store_data <= fwd_rs2;
            ex_rd         <= id_rd;
            ex_reg_write  <= id_reg_write;
            ex_mem_read   <= id_mem_read;
            ex_pc         <= id_pc;
        end
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: table of forwarding vectors plus
// hand-written load-use, saturation and reset-mid-bubble sequences.
module tb_id_ex_operand_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 2;

    logic             clk;
    logic             rst;
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [4:0]       id_rd;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             id_use_imm;
    logic [XLEN-1:0]  id_imm;
    logic [XLEN-1:0]  id_pc;
    logic [XLEN-1:0]  rf_data1;
    logic [XLEN-1:0]  rf_data2;
    logic [XLEN-1:0]  ex_alu_result;
    logic [4:0]       mem_rd;
    logic             mem_reg_write;
    logic [XLEN-1:0]  mem_data;
    logic [4:0]       wb_rd;
    logic             wb_reg_write;
    logic [XLEN-1:0]  wb_data;
    logic             flush;
    logic             stall_id;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_op_a;
    logic [XLEN-1:0]  ex_op_b;
    logic [XLEN-1:0]  ex_store_data;
    logic [4:0]       ex_rd;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic [XLEN-1:0]  ex_pc;
    logic [CNT_W-1:0] bubble_count;

    int errors = 0;
    int checks = 0;
    int exp_count = 0;

    id_ex_operand_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_use_imm(id_use_imm),
        .id_imm(id_imm), .id_pc(id_pc), .rf_data1(rf_data1), .rf_data2(rf_data2),
        .ex_alu_result(ex_alu_result), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .mem_data(mem_data), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .flush(flush), .stall_id(stall_id), .ex_valid(ex_valid), .ex_op_a(ex_op_a),
        .ex_op_b(ex_op_b), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_pc(ex_pc),
        .bubble_count(bubble_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  ex_rd;  logic ex_rw; logic ex_mr; logic [31:0] alu;
        logic [4:0]  mem_rd; logic mem_rw; logic [31:0] mem_d;
        logic [4:0]  wb_rd;  logic wb_rw;  logic [31:0] wb_d;
        logic        idv;    logic [4:0] rs1; logic [4:0] rs2; logic u1; logic u2;
        logic [4:0]  rd;     logic rw; logic mr; logic ui;
        logic [31:0] imm;    logic [31:0] pc; logic [31:0] rf1; logic [31:0] rf2;
        logic        fl;
        logic        e_stall; logic e_valid;
        logic [31:0] e_a;     logic [31:0] e_b; logic [31:0] e_sd;
    } vec_t;

    vec_t vecs[10];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic driveIdle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        id_rd = 0; id_reg_write = 0; id_mem_read = 0; id_use_imm = 0; id_imm = 0; id_pc = 0;
        rf_data1 = 0; rf_data2 = 0; ex_alu_result = 0;
        mem_rd = 0; mem_reg_write = 0; mem_data = 0;
        wb_rd = 0; wb_reg_write = 0; wb_data = 0; flush = 0;
    endtask

    // Loads EX with a setup instruction, then presents the vector in ID for one edge.
    task automatic applyStimulus(input int i);
        vec_t v;
        v = vecs[i];
        @(negedge clk);
        driveIdle();
        id_valid = 1; id_rd = v.ex_rd; id_reg_write = v.ex_rw; id_mem_read = v.ex_mr;
        @(negedge clk);
        driveIdle();
        ex_alu_result = v.alu;
        mem_rd = v.mem_rd; mem_reg_write = v.mem_rw; mem_data = v.mem_d;
        wb_rd = v.wb_rd; wb_reg_write = v.wb_rw; wb_data = v.wb_d;
        id_valid = v.idv; id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
        id_rd = v.rd; id_reg_write = v.rw; id_mem_read = v.mr; id_use_imm = v.ui;
        id_imm = v.imm; id_pc = v.pc; rf_data1 = v.rf1; rf_data2 = v.rf2; flush = v.fl;
        #1;
        checkOutput($sformatf("v%0d stall_id", i), 32'(stall_id), 32'(v.e_stall));
        @(negedge clk);
        checkOutput($sformatf("v%0d ex_valid", i), 32'(ex_valid), 32'(v.e_valid));
        if (v.e_valid) begin
            checkOutput($sformatf("v%0d ex_op_a", i), ex_op_a, v.e_a);
            checkOutput($sformatf("v%0d ex_op_b", i), ex_op_b, v.e_b);
            checkOutput($sformatf("v%0d ex_store_data", i), ex_store_data, v.e_sd);
            checkOutput($sformatf("v%0d ex_rd", i), 32'(ex_rd), 32'(v.rd));
            checkOutput($sformatf("v%0d ex_reg_write", i), 32'(ex_reg_write), 32'(v.rw));
            checkOutput($sformatf("v%0d ex_mem_read", i), 32'(ex_mem_read), 32'(v.mr));
            checkOutput($sformatf("v%0d ex_pc", i), ex_pc, v.pc);
        end else begin
            checkOutput($sformatf("v%0d ex_reg_write", i), 32'(ex_reg_write), 32'd0);
            checkOutput($sformatf("v%0d ex_mem_read", i), 32'(ex_mem_read), 32'd0);
        end
        checkOutput($sformatf("v%0d bubble_count", i), 32'(bubble_count), 32'(exp_count));
    endtask

    // LW x3 in EX, ID reads rs2=x3: one stall, one bubble, then load data via MEM.
    task automatic loadUse(input logic [31:0] val);
        @(negedge clk);
        driveIdle();
        id_valid = 1; id_rd = 3; id_reg_write = 1; id_mem_read = 1; id_pc = 32'h300;
        @(negedge clk);
        driveIdle();
        id_valid = 1; id_rd = 8; id_reg_write = 1; id_pc = 32'h304;
        id_rs1 = 1; id_uses_rs1 = 1; rf_data1 = 32'h11;
        id_rs2 = 3; id_uses_rs2 = 1; rf_data2 = 32'h22;
        id_use_imm = 1; id_imm = 32'h100;
        #1;
        checkOutput("lu stall_id asserted", 32'(stall_id), 32'd1);
        @(negedge clk);
        if (exp_count < 3) exp_count++;
        checkOutput("lu bubble ex_valid", 32'(ex_valid), 32'd0);
        checkOutput("lu bubble ex_reg_write", 32'(ex_reg_write), 32'd0);
        checkOutput("lu bubble ex_mem_read", 32'(ex_mem_read), 32'd0);
        checkOutput("lu bubble_count", 32'(bubble_count), 32'(exp_count));
        checkOutput("lu stall_id one cycle", 32'(stall_id), 32'd0);
        mem_rd = 3; mem_reg_write = 1; mem_data = val;
        @(negedge clk);
        checkOutput("lu ex_valid", 32'(ex_valid), 32'd1);
        checkOutput("lu ex_store_data", ex_store_data, val);
        checkOutput("lu ex_op_a", ex_op_a, 32'h11);
        checkOutput("lu ex_op_b", ex_op_b, 32'h100);
        checkOutput("lu ex_rd", 32'(ex_rd), 32'd8);
        checkOutput("lu ex_pc", ex_pc, 32'h304);
    endtask

    initial begin
        vecs[0] = '{ex_rd:5, ex_rw:1, alu:32'h10, idv:1, rs1:5, u1:1, rf1:32'h99, ui:1, imm:32'h4,
                    rd:10, rw:1, pc:32'h100, e_valid:1, e_a:32'h10, e_b:32'h4, e_sd:32'h0, default:'0};
        vecs[1] = '{ex_rd:7, ex_rw:1, alu:32'h1, mem_rd:7, mem_rw:1, mem_d:32'h2, wb_rd:7, wb_rw:1, wb_d:32'h3,
                    idv:1, rs1:7, u1:1, rs2:7, u2:1, rf1:32'hAA, rf2:32'hBB, rd:11, rw:1, pc:32'h104,
                    e_valid:1, e_a:32'h1, e_b:32'h1, e_sd:32'h1, default:'0};
        vecs[2] = '{ex_rd:9, ex_rw:1, alu:32'h55, mem_rd:7, mem_rw:1, mem_d:32'h2, wb_rd:7, wb_rw:1, wb_d:32'h3,
                    idv:1, rs1:7, u1:1, rs2:9, u2:1, rf1:32'hAA, rf2:32'hBB, rd:12, rw:1, pc:32'h108,
                    e_valid:1, e_a:32'h2, e_b:32'h55, e_sd:32'h55, default:'0};
        vecs[3] = '{ex_rd:7, ex_rw:0, alu:32'h1, mem_rd:7, mem_rw:0, mem_d:32'h2, wb_rd:7, wb_rw:1, wb_d:32'h3,
                    idv:1, rs1:7, u1:1, rs2:6, u2:1, rf1:32'hAA, rf2:32'h66, rd:13, rw:1, mr:1, pc:32'h10C,
                    e_valid:1, e_a:32'h3, e_b:32'h66, e_sd:32'h66, default:'0};
        vecs[4] = '{ex_rd:0, ex_rw:1, alu:32'h77, mem_rd:0, mem_rw:1, mem_d:32'hDEAD, wb_rd:0, wb_rw:1,
                    wb_d:32'hBEEF, idv:1, rs1:0, u1:1, rs2:0, u2:1, rf1:32'h1234, rf2:32'h5678,
                    rd:0, rw:0, pc:32'h110, e_valid:1, e_a:32'h0, e_b:32'h0, e_sd:32'h0, default:'0};
        vecs[5] = '{ex_rd:3, ex_rw:1, ex_mr:1, alu:32'h33, idv:1, rs1:1, u1:1, rf1:32'hA, rs2:3, u2:0,
                    rf2:32'hBB, ui:1, imm:32'h8, rd:14, rw:1, pc:32'h114,
                    e_stall:0, e_valid:1, e_a:32'hA, e_b:32'h8, e_sd:32'hBB, default:'0};
        vecs[6] = '{ex_rd:3, ex_rw:1, ex_mr:1, idv:1, rs2:3, u2:1, rd:15, rw:1, pc:32'h118, fl:1,
                    e_stall:0, e_valid:0, default:'0};
        vecs[7] = '{ex_rd:3, ex_rw:1, ex_mr:1, idv:0, rs2:3, u2:1, rd:16, rw:1, pc:32'h11C,
                    e_stall:0, e_valid:0, default:'0};
        vecs[8] = '{ex_rd:1, ex_rw:1, alu:32'h11, mem_rd:4, mem_rw:1, mem_d:32'h40, wb_rd:4, wb_rw:1,
                    wb_d:32'h50, idv:1, rs1:2, u1:1, rf1:32'h22, rs2:4, u2:1, rf2:32'h99, rd:16, rw:1,
                    pc:32'h120, e_valid:1, e_a:32'h22, e_b:32'h40, e_sd:32'h40, default:'0};
        vecs[9] = '{ex_rd:8, ex_rw:1, ex_mr:1, alu:32'h88, wb_rd:8, wb_rw:1, wb_d:32'h80, idv:1, rs1:8,
                    u1:0, rf1:32'hCC, rs2:0, ui:1, imm:32'hFFFF_FFF0, rd:17, rw:1, pc:32'h124,
                    e_valid:1, e_a:32'h80, e_b:32'hFFFF_FFF0, e_sd:32'h0, default:'0};

        driveIdle();
        rst = 1'b0;
        #3;
        checkOutput("reset ex_valid", 32'(ex_valid), 32'd0);
        checkOutput("reset ex_op_a", ex_op_a, 32'd0);
        checkOutput("reset bubble_count", 32'(bubble_count), 32'd0);
        checkOutput("reset stall_id", 32'(stall_id), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(i);
        end

        loadUse(32'h44);
        for (int k = 0; k < 3; k++) begin
            loadUse(32'h1000 + 32'(k));
        end
        checkOutput("saturated bubble_count", 32'(bubble_count), 32'd3);

        // Reset while the stage sits in BUBBLE: outputs clear before any clock edge.
        @(negedge clk);
        driveIdle();
        id_valid = 1; id_rd = 3; id_reg_write = 1; id_mem_read = 1;
        @(negedge clk);
        driveIdle();
        id_valid = 1; id_rs2 = 3; id_uses_rs2 = 1; id_rd = 9; id_reg_write = 1; id_pc = 32'h400;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        exp_count = 0;
        checkOutput("rst mid-bubble bubble_count", 32'(bubble_count), 32'd0);
        checkOutput("rst mid-bubble ex_valid", 32'(ex_valid), 32'd0);
        checkOutput("rst mid-bubble ex_reg_write", 32'(ex_reg_write), 32'd0);
        checkOutput("rst mid-bubble stall_id", 32'(stall_id), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        rf_data1 = 32'h5A; id_rs1 = 2; id_uses_rs1 = 1;
        @(negedge clk);
        checkOutput("after rst ex_valid", 32'(ex_valid), 32'd1);
        checkOutput("after rst ex_op_a", ex_op_a, 32'h5A);
        checkOutput("after rst ex_pc", ex_pc, 32'h400);
        checkOutput("after rst bubble_count", 32'(bubble_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID→EX pipeline stage of the RISC-V pipelined core, directly downstream of the register file.
- Consumes register-file read data and the decoded fields of the instruction in ID.
- Resolves data hazards by priority forwarding from EX, MEM and WB, and inserts one bubble on load-use.
- Registers the final operands and control for the EX stage.

Parameters:
XLEN, 32, datapath width.
CNT_W, 16, width of the saturating bubble counter.

Ports:
clk  in  1  core clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
id_valid  in  1  valid instruction present in ID
id_rs1  in  5  source register 1
id_rs2  in  5  source register 2
id_uses_rs1  in  1  instruction reads rs1
id_uses_rs2  in  1  instruction reads rs2
id_rd  in  5  destination register
id_reg_write  in  1  instruction writes rd
id_mem_read  in  1  instruction is a load
id_use_imm  in  1  operand B is the immediate
id_imm  in  XLEN  sign-extended immediate
id_pc  in  XLEN  instruction PC
rf_data1  in  XLEN  register file read data for rs1, aligned with id_* fields
rf_data2  in  XLEN  register file read data for rs2, aligned with id_* fields
ex_alu_result  in  XLEN  combinational result of the instruction currently held in EX
mem_rd  in  5  MEM-stage destination register
mem_reg_write  in  1  MEM-stage write enable
mem_data  in  XLEN  MEM-stage result, including load data
wb_rd  in  5  WB-stage destination register
wb_reg_write  in  1  WB-stage write enable
wb_data  in  XLEN  WB-stage write data
flush  in  1  synchronous kill of ID→EX transfer
stall_id  out  1  hold PC/IF/ID (combinational)
ex_valid  out  1  EX holds a valid instruction
ex_op_a  out  XLEN  EX operand A
ex_op_b  out  XLEN  EX operand B
ex_store_data  out  XLEN  forwarded rs2 value for stores
ex_rd  out  5  EX destination register
ex_reg_write  out  1  EX write enable
ex_mem_read  out  1  EX is a load
ex_pc  out  XLEN  EX PC
bubble_count  out  CNT_W  number of load-use bubbles inserted, saturating

Behaviour:
- Reset (rst=0, async): all outputs and registers 0; FSM in RUN.
- Forwarding (combinational, per source s ∈ {rs1, rs2}), highest priority first:
  - EX: ex_valid & ex_reg_write & !ex_mem_read & ex_rd==s → ex_alu_result
  - MEM: mem_reg_write & mem_rd==s → mem_data
  - WB: wb_reg_write & wb_rd==s → wb_data
  - otherwise rf_data1 / rf_data2
  - s==0 always yields 0; no forwarding for x0.
- Load-use hazard (combinational): id_valid & ex_valid & ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)). A source with uses=0 never triggers a hazard.
- stall_id = hazard & !flush.
- FSM:
  - RUN → BUBBLE on hazard: EX loads a bubble (ex_valid=0, ex_reg_write=0, ex_mem_read=0); bubble_count+1, saturating at all-ones.
  - BUBBLE → RUN unconditionally after one cycle. The load is now in MEM and its data forwards via mem_data.
  - A second consecutive stall is impossible because the bubble cleared ex_valid.
- Normal transfer (no hazard, no flush), on the clock edge:
  - ex_valid<=id_valid
  - ex_op_a<=fwd(rs1)
  - ex_op_b<= id_use_imm ? id_imm : fwd(rs2)
  - ex_store_data<=fwd(rs2)
  - rd, reg_write, mem_read, pc copied from ID
- id_valid=0: EX receives a bubble; no stall; counter unchanged.
- Control bits: ex_reg_write and ex_mem_read are forced 0 whenever ex_valid is 0.
- flush=1 (highest priority over hazard): EX receives a bubble, stall_id=0, FSM→RUN, counter unchanged.
- Reset mid-stall: FSM returns to RUN, bubble in EX, counter cleared.
- Latency: one cycle from ID fields to EX outputs.

Test Plan:
- ALU-use: ADD x5 in EX (ex_alu_result=0x10), ID reads rs1=x5 with rf_data1=0x99 → ex_op_a=0x10, stall_id=0.
- Priority: EX, MEM and WB all target x7 with 1, 2, 3 → ex_op_a=1. With the EX entry removed → 2. With EX and MEM removed → 3.
- x0 protection: MEM writes x0=0xDEAD, ID reads rs1=x0 → ex_op_a=0.
- Load-use: LW x3 in EX, ID uses rs2=x3 → stall_id=1 for exactly one cycle, one bubble, bubble_count=1. Next cycle mem_data=0x44 → ex_store_data=0x44.
- No false stall: LW x3 in EX, ID uses_rs2=0 and rs2 field=x3 → no stall.
- Flush during hazard: flush=1 with a load-use condition present → stall_id=0, ex_valid=0, count unchanged. Async rst low mid-BUBBLE → all outputs 0 immediately.
